reset_source: RTL and testbench

RESET_SOURCE -- requirements
Module: reset_source

---
 rtl/reset_source_pkg.sv | 7 +
 rtl/debounce.sv | 27 ++
 rtl/reset_source.sv | 66 ++++++
 tb/tb_reset_source.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/reset_source_pkg.sv
// reset_source_pkg: FSM encoding and cause bit positions shared by the reset source
package reset_source_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, RELEASE = 2'd2} state_t;
  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;
endpackage

// File: rtl/debounce.sv
// debounce: 2-flop synchroniser followed by a stability-counter debouncer
module debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic ck,
  input  logic rst_n,
  input  logic in,
  output logic out
);
  localparam int W = $clog2(DEBOUNCE) + 1;
  localparam logic [W-1:0] LAST = W'(DEBOUNCE - 1);
  logic s1, s2;
  logic [W-1:0] cnt;
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      s1  <= in;
      s2  <= s1;
      cnt <= (s2 == out || cnt == LAST) ? '0 : cnt + 1'b1;
      out <= (s2 != out && cnt == LAST) ? s2 : out;
    end
  end
endmodule

// File: rtl/reset_source.sv
// reset_source: merges button, software and watchdog events into a fixed-length
// reset request and records which sources caused it
import reset_source_pkg::*;
module reset_source #(
  parameter int DEBOUNCE    = 16,
  parameter int WDT_TIMEOUT = 1000000,
  parameter int PULSE_LEN   = 4
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       sw_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       cause_clr,
  output logic       rst_req,
  output logic [2:0] cause
);
  localparam int WW = $clog2(WDT_TIMEOUT) + 1;
  localparam int PW = $clog2(PULSE_LEN) + 1;
  localparam logic [WW-1:0] WLAST = WW'(WDT_TIMEOUT - 1);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_LEN - 1);
  state_t state, state_n;
  logic btn_db, btn_q, btn_ev, wdt_hit, go;
  logic [WW-1:0] wdt_cnt;
  logic [PW-1:0] p;
  logic [2:0] ev;
  debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
    .ck   (ck),
    .rst_n(rst_n),
    .in   (btn),
    .out  (btn_db)
  );
  assign btn_ev  = btn_db & ~btn_q;
  assign wdt_hit = wdt_en && state == IDLE && !wdt_kick && wdt_cnt == WLAST;
  always_comb begin
    ev = '0;
    ev[CAUSE_BTN] = btn_ev;
    ev[CAUSE_SW]  = sw_req;
    ev[CAUSE_WDT] = wdt_hit;
  end
  assign go = state == IDLE && |ev;
  // a held button keeps the FSM in RELEASE so it cannot retrigger
  always_comb begin
    state_n = (state == IDLE)   ? (go ? ASSERT : IDLE) :
              (state == ASSERT) ? (p == PLAST ? RELEASE : ASSERT) :
                                  (btn_db ? RELEASE : IDLE);
  end
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      btn_q   <= 1'b0;
      wdt_cnt <= '0;
      p       <= '0;
      rst_req <= 1'b0;
      cause   <= '0;
    end else begin
      state   <= state_n;
      btn_q   <= btn_db;
      wdt_cnt <= (!wdt_en || state != IDLE || wdt_kick || wdt_hit) ? '0 : wdt_cnt + 1'b1;
      p       <= (state == ASSERT && state_n == ASSERT) ? p + 1'b1 : '0;
      rst_req <= state_n == ASSERT;
      cause   <= (cause_clr ? 3'b000 : cause) | (go ? ev : 3'b000);
    end
  end
endmodule

// File: tb/tb_reset_source.sv
// tb_reset_source: directed vectors for reset_source with DEBOUNCE=4, WDT_TIMEOUT=16, PULSE_LEN=3
module tb_reset_source;
  logic ck = 1'b0, rst_n = 1'b0, btn = 1'b0, sw_req = 1'b0, wdt_en = 1'b0, wdt_kick = 1'b0, cause_clr = 1'b0;
  logic rst_req;
  logic [2:0] cause;
  int n_vec = 0, n_bad = 0;
  logic seen;
  reset_source #(.DEBOUNCE(4), .WDT_TIMEOUT(16), .PULSE_LEN(3)) dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .btn      (btn),
    .sw_req   (sw_req),
    .wdt_en   (wdt_en),
    .wdt_kick (wdt_kick),
    .cause_clr(cause_clr),
    .rst_req  (rst_req),
    .cause    (cause)
  );
  always #5 ck = ~ck;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask
  task automatic pulse_check(input string tag);
    chk({tag, "_p1"}, rst_req, 1);
    tick(1);
    chk({tag, "_p2"}, rst_req, 1);
    tick(1);
    chk({tag, "_p3"}, rst_req, 1);
    tick(1);
    chk({tag, "_end"}, rst_req, 0);
  endtask
  initial begin
    #1;
    chk("rst_req_in_reset", rst_req, 0);
    chk("cause_in_reset", cause, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_req_idle", rst_req, 0);
    sw_req = 1'b1;
    #1;
    chk("sw_same_cycle", rst_req, 0);
    tick(1);
    sw_req = 1'b0;
    pulse_check("sw");
    chk("sw_cause", cause, 3'b010);
    tick(2);
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    chk("clr_idle", cause, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn = i[1];
      tick(1);
      seen |= rst_req;
    end
    btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen |= rst_req;
    end
    chk("bounce_no_req", seen, 0);
    btn = 1'b1;
    tick(6);
    chk("btn_pre", rst_req, 0);
    tick(1);
    pulse_check("btn");
    chk("btn_cause", cause, 3'b001);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seen |= rst_req;
    end
    chk("btn_hold_no_retrig", seen, 0);
    btn = 1'b0;
    tick(10);
    btn = 1'b1;
    tick(6);
    chk("btn2_pre", rst_req, 0);
    tick(1);
    pulse_check("btn2");
    btn = 1'b0;
    tick(10);
    chk("btn2_cause", cause, 3'b001);
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    wdt_en = 1'b1;
    tick(15);
    chk("wdt_pre", rst_req, 0);
    tick(1);
    pulse_check("wdt");
    wdt_en = 1'b0;
    chk("wdt_cause", cause, 3'b100);
    tick(2);
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    wdt_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      wdt_kick = (i % 10 == 9);
      tick(1);
      seen |= rst_req;
    end
    wdt_kick = 1'b0;
    wdt_en = 1'b0;
    chk("kick_no_req", seen, 0);
    chk("kick_cause", cause, 0);
    tick(1);
    wdt_en = 1'b1;
    tick(15);
    sw_req = 1'b1;
    tick(1);
    chk("coin_p1", rst_req, 1);
    tick(1);
    sw_req = 1'b0;
    chk("coin_p2", rst_req, 1);
    tick(1);
    chk("coin_p3", rst_req, 1);
    tick(1);
    chk("coin_end", rst_req, 0);
    wdt_en = 1'b0;
    chk("coin_cause", cause, 3'b110);
    tick(3);
    chk("coin_no_retrig", rst_req, 0);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    chk("mid_p1", rst_req, 1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", rst_req, 0);
    chk("mid_cause", cause, 0);
    tick(1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen |= rst_req;
    end
    chk("post_rst_no_req", seen, 0);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    pulse_check("post_rst");
    tick(2);
    wdt_en = 1'b1;
    tick(16);
    pulse_check("wdt2");
    wdt_en = 1'b0;
    tick(2);
    chk("wdt2_cause", cause, 3'b110);
    cause_clr = 1'b1;
    sw_req = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    sw_req = 1'b0;
    chk("clr_with_sw", cause, 3'b010);
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
